// File: rtl/usreg_param.sv
// Parametrised universal shift register with a valid/ready command interface.
// Multi-bit shifts take one bit per cycle. Define USREG_PARITY_EN to add the parity_out port.
module usreg_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] shamt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
`ifdef USREG_PARITY_EN
    output logic             parity_out,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_NOP   = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] rem_q;
    logic [WIDTH-1:0] data_q;
    logic             sout_q;
    logic             done_q;
    logic             busy_q;
    logic             ready_q;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_data_d;
    logic             step_sout_d;
    logic             mode_is_shift;

    // One 1-bit step: live mode while idle, latched mode while shifting
    always_comb begin
        step_mode   = (state_q == SHIFT) ? mode_q : mode;
        step_data_d = data_q;
        step_sout_d = sout_q;
        case (step_mode)
            MODE_SHR: begin
                step_data_d = {serial_in, data_q[WIDTH-1:1]};
                step_sout_d = data_q[0];
            end
            MODE_SHL: begin
                step_data_d = {data_q[WIDTH-2:0], serial_in};
                step_sout_d = data_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_data_d = {data_q[0], data_q[WIDTH-1:1]};
                step_sout_d = data_q[0];
            end
            MODE_ROL: begin
                step_data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_sout_d = data_q[WIDTH-1];
            end
            MODE_ASR: begin
                step_data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_sout_d = data_q[0];
            end
            default: ;
        endcase
    end

    assign mode_is_shift = (mode != MODE_NOP) && (mode != MODE_LOAD) && (mode != MODE_CLEAR);

    // Command FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_NOP;
            rem_q   <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        mode_q <= mode;
                        done_q <= 1'b1;
                        if (mode_is_shift && (shamt != '0)) begin
                            data_q <= step_data_d;
                            sout_q <= step_sout_d;
                            if (shamt != CNT_W'(1)) begin
                                state_q <= SHIFT;
                                rem_q   <= shamt - CNT_W'(1);
                                busy_q  <= 1'b1;
                                ready_q <= 1'b0;
                                done_q  <= 1'b0;
                            end
                        end else if (mode == MODE_LOAD) begin
                            data_q <= data_in;
                        end else if (mode == MODE_CLEAR) begin
                            data_q <= '0;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= step_data_d;
                    sout_q <= step_sout_d;
                    rem_q  <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign serial_out = sout_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_ready  = ready_q;
`ifdef USREG_PARITY_EN
    assign parity_out = ^data_q;
`endif

endmodule

// File: tb/tb_usreg_param.sv
// Self-checking bench for usreg_param (WIDTH=8, CNT_W=3): directed plan steps plus
// random commands checked against an arithmetic reference model.
module tb_usreg_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] mode;
    logic [2:0] shamt;
    logic [7:0] data_in;
    logic       serial_in;
    logic [7:0] data_out;
    logic       serial_out;
    logic       busy;
    logic       done;
`ifdef USREG_PARITY_EN
    logic       parity_out;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int m_data  = 0;
    int m_sout  = 0;

    usreg_param #(.WIDTH(8), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .mode       (mode),
        .shamt      (shamt),
        .data_in    (data_in),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .serial_out (serial_out),
`ifdef USREG_PARITY_EN
        .parity_out (parity_out),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Whole-command result computed arithmetically from the mode rules
    function automatic void ref_cmd(input int md, input int n, input int din, input int sin,
                                    inout int d, inout int so, output int lat);
        int k;
        lat = 1;
        if (md == 3) d = din;
        else if (md == 7) d = 0;
        else if (md != 0 && n > 0) begin
            lat = n;
            k   = n % 8;
            case (md)
                1: begin so = (d >> (n - 1)) & 1; d = ((d >> n) | (sin != 0 ? (255 << (8 - n)) : 0)) & 255; end
                2: begin so = (d >> (8 - n)) & 1; d = ((d << n) | (sin != 0 ? ((1 << n) - 1) : 0)) & 255; end
                4: begin so = (d >> ((n - 1) % 8)) & 1; d = ((d >> k) | (d << (8 - k))) & 255; end
                5: begin so = (d >> ((8 - k) % 8)) & 1; d = ((d << k) | (d >> (8 - k))) & 255; end
                default: begin
                    so = (d >> (n - 1)) & 1;
                    d  = ((d >> n) | ((d & 128) != 0 ? (255 << (8 - n)) : 0)) & 255;
                end
            endcase
        end
    endfunction

    task automatic run_cmd(input int md, input int n, input int din, input int sin, input string tag);
        int cyc;
        int lat;
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        mode      = 3'(md);
        shamt     = 3'(n);
        data_in   = 8'(din);
        serial_in = 1'(sin);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        ref_cmd(md, n, din, sin, m_data, m_sout, lat);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_data"}, 32'(data_out), 32'(m_data));
        check({tag, "_sout"}, 32'(serial_out), 32'(m_sout));
        check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef USREG_PARITY_EN
        check({tag, "_parity"}, 32'(parity_out), 32'(^8'(m_data)));
`endif
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dummy_lat;
        int exp_sout;
        int exp_data;
        // Reset held with a pending LOAD
        rst = 1'b1; cmd_valid = 1'b1; mode = 3'b011; shamt = 3'd0; data_in = 8'hFF; serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sout", 32'(serial_out), 32'd0);
        rst = 1'b0; cmd_valid = 1'b0;

        run_cmd(3, 0, 'hA5, 0, "load_a5");
        check("load_a5_val", 32'(data_out), 32'hA5);

        // ROR by 3 with an ignored CLEAR while busy
        exp_data = m_data; exp_sout = m_sout;
        ref_cmd(4, 3, 0, 0, exp_data, exp_sout, dummy_lat);
        mode = 3'b100; shamt = 3'd3; cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("ror_step1", 32'(data_out), 32'hD2);
        check("ror_busy1", 32'(busy), 32'd1);
        check("ror_ready1", 32'(cmd_ready), 32'd0);
        mode = 3'b111; cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("ror_step2", 32'(data_out), 32'h69);
        check("ror_busy2", 32'(busy), 32'd1);
        check("ror_done2", 32'(done), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("ror_step3", 32'(data_out), 32'hB4);
        check("ror_done3", 32'(done), 32'd1);
        check("ror_busy3", 32'(busy), 32'd0);
        check("ror_sout", 32'(serial_out), 32'(exp_sout));
        m_data = exp_data; m_sout = exp_sout;
        @(posedge clk); #1;
        check("ror_clear_ignored", 32'(data_out), 32'hB4);
        check("ror_done_gone", 32'(done), 32'd0);

        run_cmd(3, 0, 'h84, 0, "load_84");
        run_cmd(6, 2, 0, 0, "asr2");
        check("asr2_val", 32'(data_out), 32'hE1);
        run_cmd(3, 0, 'h0F, 0, "load_0f");
        run_cmd(2, 4, 0, 1, "shl4");
        check("shl4_val", 32'(data_out), 32'hFF);

        // ROL 7 aborted by reset
        run_cmd(3, 0, 'h81, 0, "load_81");
        mode = 3'b101; shamt = 3'd7; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_data = 0; m_sout = 0;
        check("abort_data", 32'(data_out), 32'h00);
        check("abort_busy_clr", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sout", 32'(serial_out), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("abort_no_done", 32'(done), 32'd0);

        // SHR 0 then CLEAR accepted in its done cycle
        run_cmd(3, 0, 'h3C, 0, "load_3c");
        mode = 3'b001; shamt = 3'd0; serial_in = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_data1", 32'(data_out), 32'h3C);
        check("b2b_sout1", 32'(serial_out), 32'(m_sout));
        check("b2b_ready1", 32'(cmd_ready), 32'd1);
        mode = 3'b111;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_data2", 32'(data_out), 32'h00);
        m_data = 0;
        @(posedge clk); #1;
        check("b2b_done_end", 32'(done), 32'd0);

`ifdef USREG_PARITY_EN
        run_cmd(3, 0, 'h07, 0, "par_07");
        check("par_07_val", 32'(parity_out), 32'd1);
        run_cmd(3, 0, 'h03, 0, "par_03");
        check("par_03_val", 32'(parity_out), 32'd0);
`endif

        // Random commands against the reference model
        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
